pipe_stage_buffer: RTL and testbench

//  Generic, parametrised inter-stage pipeline register for the core pipeline (IF/ID/EXE/MEM).

---
 rtl/pipe_stage_buffer_if.sv | 25 ++
 rtl/pipe_stage_buffer.sv | 131 +++++++++++++
 tb/tb_pipe_stage_buffer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_buffer_if.sv
// Valid/ready handshake bundle for one pipeline stage boundary.
// The master drives the word forward and the slave answers with ready.
interface pipe_stage_buffer_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (
        output valid,
        output data,
        output ctrl,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  ctrl,
        output ready
    );
endinterface

// File: rtl/pipe_stage_buffer.sv
// Inter-stage pipeline register with valid/ready handshake, flush, optional skid entry
// and a saturating back-pressure cycle counter. Control bits read as zero for any bubble.
module pipe_stage_buffer #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    pipe_stage_buffer_if.slave   in_if,
    pipe_stage_buffer_if.master  out_if,
    output logic [CNT_W-1:0]     stall_cycles
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FULL,
        ST_SKID
    } state_t;

    localparam logic [CNT_W-1:0] STALL_MAX = '1;
    localparam bit               HAS_SKID  = (SKID != 0);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
    logic                out_valid_q, out_valid_d;
    logic                in_ready_q, in_ready_d;
    logic [CNT_W-1:0]    stall_q, stall_d;

    logic                in_ready;
    logic                accept;
    logic                drain;

    // Without a skid entry the buffer may refill in the cycle it drains, so ready looks through.
    assign in_ready = in_ready_q | (!HAS_SKID && out_if.ready);
    assign accept   = in_if.valid & in_ready;
    assign drain    = out_valid_q & out_if.ready;

    assign in_if.ready   = in_ready;
    assign out_if.valid  = out_valid_q;
    assign out_if.data   = main_data_q;
    assign out_if.ctrl   = out_valid_q ? main_ctrl_q : '0;
    assign stall_cycles  = stall_q;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        stall_d     = stall_q;

        if (out_valid_q && !out_if.ready && (stall_q != STALL_MAX)) begin
            stall_d = stall_q + CNT_W'(1);
        end

        if (flush) begin
            state_d     = ST_EMPTY;
            main_data_d = '0;
            main_ctrl_d = '0;
            skid_data_d = '0;
            skid_ctrl_d = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d     = ST_FULL;
                        main_data_d = in_if.data;
                        main_ctrl_d = in_if.ctrl;
                    end
                end
                ST_FULL: begin
                    if (accept && drain) begin
                        main_data_d = in_if.data;
                        main_ctrl_d = in_if.ctrl;
                    end else if (accept && HAS_SKID) begin
                        state_d     = ST_SKID;
                        skid_data_d = in_if.data;
                        skid_ctrl_d = in_if.ctrl;
                    end else if (drain) begin
                        state_d     = ST_EMPTY;
                        main_ctrl_d = '0;
                    end
                end
                ST_SKID: begin
                    if (drain) begin
                        state_d     = ST_FULL;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    main_ctrl_d = '0;
                end
            endcase
        end

        // Handshake outputs are decoded from the next state so they come straight off flops.
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = HAS_SKID ? (state_d != ST_SKID) : (state_d == ST_EMPTY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            stall_q     <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed bench: one skid instance with a 4-bit stall counter and one single-entry instance,
// each checked against hand-computed values.
module tb_pipe_stage_buffer;

    logic        clk;
    logic        rst;
    logic        flush_a;
    logic        flush_b;
    logic [3:0]  stall_a;
    logic [15:0] stall_b;

    int checks;
    int failures;

    pipe_stage_buffer_if #(.DATA_W(32), .CTRL_W(8)) a_in ();
    pipe_stage_buffer_if #(.DATA_W(32), .CTRL_W(8)) a_out ();
    pipe_stage_buffer_if #(.DATA_W(32), .CTRL_W(8)) b_in ();
    pipe_stage_buffer_if #(.DATA_W(32), .CTRL_W(8)) b_out ();

    pipe_stage_buffer #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(4)) dut_a (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush_a),
        .in_if        (a_in.slave),
        .out_if       (a_out.master),
        .stall_cycles (stall_a)
    );

    pipe_stage_buffer #(.DATA_W(32), .CTRL_W(8), .SKID(0), .CNT_W(16)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush_b),
        .in_if        (b_in.slave),
        .out_if       (b_out.master),
        .stall_cycles (stall_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic vld, input logic [31:0] data, input logic [7:0] ctrl,
                                 input logic ordy);
        a_in.valid   = vld;
        a_in.data    = data;
        a_in.ctrl    = ctrl;
        a_out.ready  = ordy;
    endtask

    task automatic applyStimulusB(input logic vld, input logic [31:0] data, input logic [7:0] ctrl,
                                  input logic ordy);
        b_in.valid   = vld;
        b_in.data    = data;
        b_in.ctrl    = ctrl;
        b_out.ready  = ordy;
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        flush_a  = 1'b0;
        flush_b  = 1'b0;
        rst      = 1'b1;
        applyStimulus(1'b1, 32'hDEAD, 8'h5A, 1'b0);
        applyStimulusB(1'b1, 32'hDEAD, 8'h5A, 1'b0);

        // Reset held two cycles with a word offered
        step();
        step();
        checkOutput("rst_out_valid", {31'b0, a_out.valid}, 32'h0);
        checkOutput("rst_out_data", a_out.data, 32'h0);
        checkOutput("rst_out_ctrl", {24'b0, a_out.ctrl}, 32'h0);
        checkOutput("rst_stall", {28'b0, stall_a}, 32'h0);
        checkOutput("rst_b_out_valid", {31'b0, b_out.valid}, 32'h0);
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 8'h0, 1'b0);
        applyStimulusB(1'b0, 32'h0, 8'h0, 1'b0);
        checkOutput("rst_in_ready", {31'b0, a_in.ready}, 32'h1);
        step();
        checkOutput("rst_idle_valid", {31'b0, a_out.valid}, 32'h0);

        // Back-to-back stream, each word visible one cycle after acceptance
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 32'(i), 8'(i), 1'b1);
            #1;
            checkOutput($sformatf("stream_in_ready_%0d", i), {31'b0, a_in.ready}, 32'h1);
            step();
            checkOutput($sformatf("stream_valid_%0d", i), {31'b0, a_out.valid}, 32'h1);
            checkOutput($sformatf("stream_data_%0d", i), a_out.data, 32'(i));
            checkOutput($sformatf("stream_ctrl_%0d", i), {24'b0, a_out.ctrl}, 32'(i));
        end
        applyStimulus(1'b0, 32'h0, 8'h0, 1'b1);
        step();
        checkOutput("stream_end_valid", {31'b0, a_out.valid}, 32'h0);
        checkOutput("stream_end_ctrl", {24'b0, a_out.ctrl}, 32'h0);
        checkOutput("stream_stall", {28'b0, stall_a}, 32'h0);

        // Back-pressure: A to main, B to skid, C held upstream
        applyStimulus(1'b1, 32'hA1, 8'h11, 1'b0);
        step();
        checkOutput("bp_a_data", a_out.data, 32'hA1);
        checkOutput("bp_in_ready_after_a", {31'b0, a_in.ready}, 32'h1);
        applyStimulus(1'b1, 32'hB2, 8'h22, 1'b0);
        step();
        checkOutput("bp_in_ready_after_b", {31'b0, a_in.ready}, 32'h0);
        checkOutput("bp_hold_a", a_out.data, 32'hA1);
        applyStimulus(1'b1, 32'hC3, 8'h33, 1'b0);
        step();
        step();
        checkOutput("bp_stable_data", a_out.data, 32'hA1);
        checkOutput("bp_stable_ctrl", {24'b0, a_out.ctrl}, 32'h11);
        checkOutput("bp_in_ready_blocked", {31'b0, a_in.ready}, 32'h0);
        checkOutput("bp_stall_blocked", {28'b0, stall_a}, 32'h3);
        applyStimulus(1'b1, 32'hC3, 8'h33, 1'b1);
        step();
        checkOutput("bp_out_b", a_out.data, 32'hB2);
        checkOutput("bp_out_b_ctrl", {24'b0, a_out.ctrl}, 32'h22);
        checkOutput("bp_in_ready_reopen", {31'b0, a_in.ready}, 32'h1);
        step();
        checkOutput("bp_out_c", a_out.data, 32'hC3);
        applyStimulus(1'b0, 32'h0, 8'h0, 1'b1);
        step();
        checkOutput("bp_drained", {31'b0, a_out.valid}, 32'h0);
        checkOutput("bp_stall_final", {28'b0, stall_a}, 32'h3);

        // Flush while in the skid state with D offered
        applyStimulus(1'b1, 32'hE1, 8'h44, 1'b0);
        step();
        applyStimulus(1'b1, 32'hF2, 8'h55, 1'b0);
        step();
        checkOutput("fl_pre_ready", {31'b0, a_in.ready}, 32'h0);
        applyStimulus(1'b1, 32'hD4, 8'h66, 1'b0);
        flush_a = 1'b1;
        step();
        flush_a = 1'b0;
        checkOutput("fl_valid", {31'b0, a_out.valid}, 32'h0);
        checkOutput("fl_ctrl", {24'b0, a_out.ctrl}, 32'h0);
        checkOutput("fl_data", a_out.data, 32'h0);
        checkOutput("fl_in_ready", {31'b0, a_in.ready}, 32'h1);
        applyStimulus(1'b0, 32'h0, 8'h0, 1'b1);
        step();
        checkOutput("fl_no_d", {31'b0, a_out.valid}, 32'h0);
        step();
        checkOutput("fl_no_d_later", {31'b0, a_out.valid}, 32'h0);

        // Counter saturation at 15 with a 4-bit counter
        applyStimulus(1'b1, 32'h77, 8'h07, 1'b0);
        step();
        applyStimulus(1'b0, 32'h0, 8'h0, 1'b0);
        for (int i = 0; i < 20; i++) step();
        checkOutput("sat_stall", {28'b0, stall_a}, 32'hF);
        checkOutput("sat_held_data", a_out.data, 32'h77);
        step();
        checkOutput("sat_stall_hold", {28'b0, stall_a}, 32'hF);
        flush_a = 1'b1;
        step();
        flush_a = 1'b0;
        checkOutput("sat_after_flush", {28'b0, stall_a}, 32'hF);
        checkOutput("sat_flush_valid", {31'b0, a_out.valid}, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("sat_after_rst", {28'b0, stall_a}, 32'h0);

        // Single-entry instance: full blocks, simultaneous drain and accept
        applyStimulusB(1'b1, 32'hB1, 8'h81, 1'b0);
        checkOutput("b_ready_empty", {31'b0, b_in.ready}, 32'h1);
        step();
        applyStimulusB(1'b1, 32'hB2, 8'h82, 1'b0);
        checkOutput("b_ready_full", {31'b0, b_in.ready}, 32'h0);
        step();
        checkOutput("b_hold_data", b_out.data, 32'hB1);
        checkOutput("b_stall", stall_b, 32'h1);
        applyStimulusB(1'b1, 32'hB2, 8'h82, 1'b1);
        checkOutput("b_ready_passthru", {31'b0, b_in.ready}, 32'h1);
        step();
        checkOutput("b_new_valid", {31'b0, b_out.valid}, 32'h1);
        checkOutput("b_new_data", b_out.data, 32'hB2);
        checkOutput("b_new_ctrl", {24'b0, b_out.ctrl}, 32'h82);
        applyStimulusB(1'b0, 32'h0, 8'h0, 1'b1);
        step();
        checkOutput("b_drained_valid", {31'b0, b_out.valid}, 32'h0);
        checkOutput("b_drained_ctrl", {24'b0, b_out.ctrl}, 32'h0);
        checkOutput("b_stall_final", stall_b, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
